// File: rtl/branch_ctrl_if.sv
// branch_ctrl_if: control/flag bus between the sequencer, the ALU and the branch controller.
interface branch_ctrl_if #(parameter int PC_W = 13);
  logic            i_start;
  logic            i_stall;
  logic            i_flag_we;
  logic            i_sc_in;
  logic            i_beq_in;
  logic            i_bgt_in;
  logic [2:0]      i_br_op;
  logic [PC_W-1:0] i_br_target;
  logic [PC_W-1:0] o_pc;
  logic            o_sc_q;
  logic            o_beq_q;
  logic            o_bgt_q;
  logic            o_br_taken;
  logic            o_halted;
  modport master (
    output i_start, i_stall, i_flag_we, i_sc_in, i_beq_in, i_bgt_in, i_br_op, i_br_target,
    input  o_pc, o_sc_q, o_beq_q, o_bgt_q, o_br_taken, o_halted
  );
  modport slave (
    input  i_start, i_stall, i_flag_we, i_sc_in, i_beq_in, i_bgt_in, i_br_op, i_br_target,
    output o_pc, o_sc_q, o_beq_q, o_bgt_q, o_br_taken, o_halted
  );
endinterface

// File: rtl/branch_ctrl.sv
// branch_ctrl: two-phase PC sequencer with registered ALU flags, conditional branches and halt.
module branch_ctrl #(
  parameter int         PC_W    = 13,
  parameter logic [2:0] HALT_OP = 3'b110
) (
  input logic          i_clk,
  input logic          i_rst_n,
  branch_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;
  state_t          r_state, w_state;
  logic [PC_W-1:0] r_pc, w_pc;
  logic [2:0]      r_flags, w_flags;
  logic            r_taken, w_taken, r_halted;
  logic            w_exec, w_take;
  logic [2:0]      w_op;
  assign w_op   = bus.i_br_op;
  assign w_exec = r_pc[0];
  // r_flags = {sc, beq, bgt}; conditions look at the flags held before this edge
  assign w_take = (w_op == 3'b001 &&  r_flags[1]) || (w_op == 3'b010 && !r_flags[1]) ||
                  (w_op == 3'b011 &&  r_flags[0]) || (w_op == 3'b100 && !r_flags[0]) ||
                  (w_op == 3'b101);
  always_comb begin
    w_state = r_state;
    w_pc    = r_pc;
    w_flags = r_flags;
    w_taken = 1'b0;
    if (!bus.i_stall)
      case (r_state)
        S_IDLE: if (bus.i_start) w_state = S_RUN;
        S_RUN:
          if (w_exec && w_op == HALT_OP) w_state = S_HALT;
          else begin
            if (w_exec && bus.i_flag_we) w_flags = {bus.i_sc_in, bus.i_beq_in, bus.i_bgt_in};
            w_taken = w_exec && w_take;
            w_pc    = w_taken ? {bus.i_br_target[PC_W-1:1], 1'b0} : r_pc + PC_W'(1);
          end
        S_HALT:
          if (bus.i_start) begin
            w_state = S_RUN;
            w_pc    = '0;
            w_flags = '0;
          end
        default: w_state = S_IDLE;
      endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_flags  <= '0;
      r_taken  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_pc     <= w_pc;
      r_flags  <= w_flags;
      r_taken  <= w_taken;
      r_halted <= (w_state == S_HALT);
    end
  end
  assign bus.o_pc       = r_pc;
  assign bus.o_sc_q     = r_flags[2];
  assign bus.o_beq_q    = r_flags[1];
  assign bus.o_bgt_q    = r_flags[0];
  assign bus.o_br_taken = r_taken;
  assign bus.o_halted   = r_halted;
endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
- REQ-001: Parameter PC_W, default 13, program counter width.
- REQ-002: Parameter HALT_OP, default 3'b110, BR_OP encoding that stops the machine.
- REQ-003: CLK  input  1  single clock; all state updates on rising edge.
- REQ-004: RST_N  input  1  reset, asynchronous, active-low.
- REQ-005: START  input  1  level; begins or restarts execution.
- REQ-006: STALL  input  1  freezes PC, flags and state while high.
- REQ-007: FLAG_WE  input  1  latch ALU flags this cycle.
- REQ-008: SC_IN  input  1  ALU carry/shift out.
- REQ-009: BEQ_IN  input  1  ALU equal flag.
- REQ-010: BGT_IN  input  1  ALU greater-than flag.
- REQ-011: BR_OP  input  3  000 none, 001 BEQ, 010 BNE, 011 BGT, 100 BLE, 101 JMP, 110 HALT, 111 none.
- REQ-012: BR_TARGET  input  PC_W  absolute branch target.
- REQ-013: PC  output  PC_W  current program counter.
- REQ-014: SC_Q  output  1  registered carry, fed back to the ALU carry-in.
- REQ-015: BEQ_Q  output  1  registered equal flag.
- REQ-016: BGT_Q  output  1  registered greater-than flag.
- REQ-017: BR_TAKEN  output  1  one-cycle pulse when a branch redirects PC.
- REQ-018: HALTED  output  1  high while in the HALT state.

Function
- REQ-019: Three states SHALL be supported: IDLE, RUN and HALT.
- REQ-020: In IDLE, START=1 SHALL move the block to RUN on the next edge, with PC unchanged.
- REQ-021: In RUN, STALL=1 SHALL hold PC, flags and state, and force BR_TAKEN=0.
- REQ-022: PC SHALL have two phases: even PC is fetch, odd PC is execute.
- REQ-023: FLAG_WE and BR_OP SHALL be honoured only in RUN, with STALL=0, when PC is odd; they SHALL be ignored on even PC.
- REQ-024: On an honoured FLAG_WE, SC_Q/BEQ_Q/BGT_Q SHALL load SC_IN/BEQ_IN/BGT_IN on the same edge.
- REQ-025: Branch conditions SHALL use the registered flags as they stood before the edge:
  - BEQ is taken if BEQ_Q=1; BNE if BEQ_Q=0;
  - BGT if BGT_Q=1; BLE if BGT_Q=0;
  - JMP is always taken.
- REQ-026: FLAG_WE and a branch in the same cycle SHALL evaluate the branch on the old flags while the new flags load.
- REQ-027: Taken branch: PC SHALL load {BR_TARGET[PC_W-1:1],1'b0} and BR_TAKEN SHALL be 1 for exactly that cycle.
- REQ-028: Not taken, in RUN: PC SHALL load PC+1 modulo 2^PC_W, so all-ones wraps to 0 with no flag.
- REQ-029: HALT_OP on odd PC SHALL move the block to HALT with PC held at the HALT instruction address; HALTED=1 from the next edge.
- REQ-030: In HALT, PC and flags SHALL be frozen and FLAG_WE/BR_OP ignored.
- REQ-031: In HALT, START=1 SHALL restart RUN with PC=0 and all flags cleared on the next edge.
- REQ-032: STALL SHALL take priority over HALT_OP and over branches.
- REQ-033: BR_TAKEN SHALL never be high in IDLE or HALT.
- REQ-034: Outputs SHALL be driven directly from registers, with no combinational path from inputs.

Reset
- REQ-035: RST_N=0 SHALL immediately, without a clock, force: state IDLE, PC=0, SC_Q=BEQ_Q=BGT_Q=0, BR_TAKEN=0, HALTED=0.
- REQ-036: Reset asserted mid-branch or in HALT SHALL discard the pending branch or halt.
- REQ-037: After RST_N deasserts, the block SHALL wait in IDLE for START.

Verification
- REQ-038: Reset, then START, run 6 cycles with BR_OP=000 -> PC 0,1,2,3,4,5; BR_TAKEN stays 0.
- REQ-039: At PC=3: FLAG_WE=1, BEQ_IN=1. At PC=5: BR_OP=001, BR_TARGET=0x0041 -> next PC=0x0040, BR_TAKEN pulses 1 cycle.
- REQ-040: At PC=7: BEQ_Q=0, FLAG_WE=1 with BEQ_IN=1, and BR_OP=001 -> not taken, PC=8, BEQ_Q=1 afterwards.
- REQ-041: PC=0x1FFF, not taken -> PC=0x0000; STALL=1 for 3 cycles -> PC and flags unchanged, BR_TAKEN=0.
- REQ-042: BR_OP=110 at PC=9 -> HALTED=1, PC stays 9; START -> PC=0, flags 0, HALTED=0.
- REQ-043: Drop RST_N asynchronously between edges during a taken JMP -> PC=0, IDLE, all outputs 0 with no edge needed.
